// File: rtl/trace_writer.sv
// trace_writer: turns PDP-11 memory-access events into ASCII trace lines
// "<type> <6 octal digits>\n", emitted one byte per accepted handshake.
// A small circular FIFO buffers events while the byte sink stalls.
module trace_writer #(
   parameter int unsigned DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic [1:0]  ev_type,
   input  logic [15:0] ev_addr,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_last,
   output logic        busy,
   output logic        err,
   output logic [31:0] lines_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state;
   logic [17:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic        accept;
   logic        push;
   logic        pop;
   logic        line_done;
   logic [17:0] head;
   logic [3:0]  idx;
   logic [1:0]  line_type;
   logic [15:0] line_addr;

   // Character at a given position of the line for {type, addr}
   function automatic logic [7:0] line_char(input logic [3:0] i,
                                            input logic [1:0] t,
                                            input logic [15:0] a);
      logic [7:0] c;
      case (i)
         4'd0:    c = {6'b001100, t};
         4'd1:    c = 8'h20;
         4'd2:    c = {7'b0011000, a[15]};
         4'd3:    c = {5'b00110, a[14:12]};
         4'd4:    c = {5'b00110, a[11:9]};
         4'd5:    c = {5'b00110, a[8:6]};
         4'd6:    c = {5'b00110, a[5:3]};
         4'd7:    c = {5'b00110, a[2:0]};
         4'd8:    c = 8'h0A;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign ev_ready  = !full;
   assign accept    = ev_valid && ev_ready;
   assign push      = accept && (ev_type != 2'd3);
   assign line_done = (state == SEND) && tx_ready && (idx == 4'd8);
   assign pop       = !empty && ((state == IDLE) || line_done);
   assign head      = mem[rd_ptr];
   assign busy      = (state == SEND) || !empty;

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ev_type, ev_addr};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Line FSM: loads a FIFO head and walks the byte index with registered tx outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         line_type <= '0;
         line_addr <= '0;
         tx_valid  <= 1'b0;
         tx_byte   <= 8'h00;
         tx_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  state     <= SEND;
                  idx       <= '0;
                  line_type <= head[17:16];
                  line_addr <= head[15:0];
                  tx_valid  <= 1'b1;
                  tx_byte   <= line_char(4'd0, head[17:16], head[15:0]);
                  tx_last   <= 1'b0;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  if (idx == 4'd8) begin
                     // Chain straight into the next line so there is no bubble
                     if (!empty) begin
                        idx       <= '0;
                        line_type <= head[17:16];
                        line_addr <= head[15:0];
                        tx_byte   <= line_char(4'd0, head[17:16], head[15:0]);
                        tx_last   <= 1'b0;
                     end else begin
                        state    <= IDLE;
                        idx      <= '0;
                        tx_valid <= 1'b0;
                        tx_byte  <= 8'h00;
                        tx_last  <= 1'b0;
                     end
                  end else begin
                     idx     <= idx + 4'd1;
                     tx_byte <= line_char(idx + 4'd1, line_type, line_addr);
                     tx_last <= (idx == 4'd7);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Count accepted newline bytes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lines_out <= '0;
      else if (line_done) lines_out <= lines_out + 32'd1;
   end

   // Sticky flag for accepted illegal (type 3) events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else if (accept && (ev_type == 2'd3)) err <= 1'b1;
   end

endmodule

// File: tb/tb_trace_writer.sv
// Self-checking bench for trace_writer: expected bytes are queued when an
// event is accepted and compared as the sink accepts each byte.
module tb_trace_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ev_valid;
   logic        ev_ready;
   logic [1:0]  ev_type;
   logic [15:0] ev_addr;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_byte;
   logic        tx_last;
   logic        busy;
   logic        err;
   logic [31:0] lines_out;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int cyc = 0;
   logic [8:0] exp_q [$];
   int acc_cyc [$];
   logic       hold_pend = 1'b0;
   logic [7:0] hold_byte;
   logic       hold_last;

   trace_writer #(.DEPTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_type   (ev_type),
      .ev_addr   (ev_addr),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_byte   (tx_byte),
      .tx_last   (tx_last),
      .busy      (busy),
      .err       (err),
      .lines_out (lines_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Byte monitor: mid-cycle sampling of what the next rising edge will accept
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_byte", {24'd0, tx_byte}, {24'd0, hold_byte});
            check("hold_last", {31'd0, tx_last}, {31'd0, hold_last});
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
         end
         hold_pend = tx_valid && !tx_ready;
         hold_byte = tx_byte;
         hold_last = tx_last;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {24'd0, tx_byte}, 32'hFFFF_FFFF);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("tx_byte", {24'd0, tx_byte}, {24'd0, e[7:0]});
               check("tx_last", {31'd0, tx_last}, {31'd0, e[8]});
            end
            acc_cnt++;
            acc_cyc.push_back(cyc);
         end
      end
   end

   task automatic push_line(input logic [1:0] t, input logic [15:0] a);
      string s;
      s = $sformatf("%0d %06o\n", t, a);
      for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), s[i]});
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send_event(input logic [1:0] t, input logic [15:0] a);
      bit ok;
      ok = 0;
      ev_valid = 1'b1;
      ev_type  = t;
      ev_addr  = a;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ev_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("ev_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      if (ok && t != 2'd3) push_line(t, a);
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check(tag, {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      check("rst_ev_ready", {31'd0, ev_ready}, 32'd1);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
      check("rst_tx_last", {31'd0, tx_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_lines_out", lines_out, 32'd0);
   endtask

   initial begin
      int base;
      int b0;
      int line_base;
      bit ok;
      logic [3:0] pat;
      rst_n    = 1'b0;
      ev_valid = 1'b0;
      ev_type  = '0;
      ev_addr  = '0;
      tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single event with latency probe
      send_event(2'd2, 16'o001000);
      @(negedge clk);
      check("lat_valid_k", {31'd0, tx_valid}, 32'd0);
      check("lat_busy_k", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("lat_valid_k1", {31'd0, tx_valid}, 32'd1);
      check("lat_first_byte", {24'd0, tx_byte}, 32'h32);
      @(posedge clk);
      #1;
      wait_idle("single_drain");
      check("single_lines", lines_out, 32'd1);

      // Address extremes, back-to-back with no bubble
      b0 = acc_cnt;
      send_event(2'd1, 16'hFFFF);
      send_event(2'd0, 16'h0000);
      wait_idle("extreme_drain");
      check("extreme_bytes", acc_cnt - b0, 32'd18);
      check("no_bubble", acc_cyc[b0 + 17] - acc_cyc[b0], 32'd17);
      check("extreme_lines", lines_out, 32'd3);

      // Backpressure pattern 1,0,0,1 repeating
      pat = 4'b1001;
      tx_ready = 1'b0;
      b0 = acc_cnt;
      send_event(2'd2, 16'o054321);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         tx_ready = pat[i % 4];
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("bp_drain", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
      check("bp_bytes", acc_cnt - b0, 32'd9);
      check("bp_lines", lines_out, 32'd4);

      // FIFO full: one line in SEND plus 8 queued, 10th refused
      tx_ready = 1'b0;
      line_base = lines_out;
      for (int i = 0; i < 9; i++) begin
         send_event(2'(i % 3), 16'(i * 16'o11111 + 7));
      end
      ev_valid = 1'b1;
      ev_type  = 2'd0;
      ev_addr  = 16'o123456;
      @(negedge clk);
      check("full_ev_ready", {31'd0, ev_ready}, 32'd0);
      check("full_busy", {31'd0, busy}, 32'd1);
      check("full_stall_byte", {24'd0, tx_byte}, 32'h30);
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      tx_ready = 1'b1;
      wait_idle("full_drain");
      check("full_lines", lines_out - line_base, 32'd9);

      // Illegal type: consumed, sets err, emits nothing
      b0 = acc_cnt;
      send_event(2'd3, 16'o000100);
      @(negedge clk);
      check("ill_err", {31'd0, err}, 32'd1);
      repeat (12) @(negedge clk);
      check("ill_busy", {31'd0, busy}, 32'd0);
      check("ill_no_bytes", acc_cnt - b0, 32'd0);
      @(posedge clk);
      #1;
      send_event(2'd0, 16'o001234);
      wait_idle("ill_follow_drain");
      check("ill_err_sticky", {31'd0, err}, 32'd1);
      check("ill_follow_bytes", acc_cnt - b0, 32'd9);

      // Reset mid-line after 4 bytes with 2 events queued
      tx_ready = 1'b0;
      send_event(2'd0, 16'o000200);
      send_event(2'd1, 16'o000300);
      send_event(2'd2, 16'o000400);
      b0 = acc_cnt;
      tx_ready = 1'b1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (acc_cnt == b0 + 4) begin
            ok = 1;
            break;
         end
      end
      check("rml_reach4", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      tx_ready = 1'b0;
      #1;
      check_reset_vals();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tx_ready = 1'b1;
      b0 = acc_cnt;
      repeat (12) @(negedge clk);
      check("rml_quiet_busy", {31'd0, busy}, 32'd0);
      check("rml_quiet_bytes", acc_cnt - b0, 32'd0);
      @(posedge clk);
      #1;
      send_event(2'd1, 16'o000200);
      wait_idle("rml_new_drain");
      check("rml_new_lines", lines_out, 32'd1);
      check("rml_new_bytes", acc_cnt - b0, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trace_writer.md
# trace_writer

Converts memory-access events from the PDP-11 core into ASCII trace-file lines, one byte at a time. Each line has the form `<type> <6 octal digits>\n`, which is the line format the simulator's trace loader parses back into `{type, address}` words. The block sits between the core's access-reporting port and a byte sink such as a file-writer task or UART. A small FIFO absorbs bursts while the sink applies backpressure.

## Interface
Parameters:
- DEPTH, 8: event FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ev_valid  input  1  event offered
- ev_ready  output  1  event can be accepted; equals !fifo_full
- ev_type  input  2  0 = data read, 1 = data write, 2 = instruction fetch, 3 = illegal
- ev_addr  input  16  byte address
- tx_valid  output  1  tx_byte holds a valid character
- tx_ready  input  1  sink accepts tx_byte
- tx_byte  output  8  ASCII character
- tx_last  output  1  high with the newline byte
- busy  output  1  FIFO non-empty or a line is in progress
- err  output  1  sticky; set when a type-3 event is accepted
- lines_out  output  32  count of newline bytes accepted; wraps modulo 2^32

## Operation
- Accept: an event is taken on a rising edge when ev_valid && ev_ready.
- Types 0–2 push {ev_type, ev_addr} into the FIFO.
- Type 3 is consumed and never enqueued. It sets err, which stays set until reset.
- Line format, 9 bytes, in this order:
  - index 0: 8'h30 | type
  - index 1: 8'h20 (space)
  - index 2: 8'h30 | {2'b0, addr[15]}
  - index 3: 8'h30 | addr[14:12]
  - index 4: 8'h30 | addr[11:9]
  - index 5: 8'h30 | addr[8:6]
  - index 6: 8'h30 | addr[5:3]
  - index 7: 8'h30 | addr[2:0]
  - index 8: 8'h0A (newline); tx_last = 1 on this byte only
- State machine:
  - IDLE: if the FIFO is non-empty, the next edge loads the head entry into the line register, pops it, sets byte index = 0, and moves to SEND.
  - SEND: tx_valid = 1. On each edge with tx_ready = 1, the byte index increments.
  - Index 8 accepted, FIFO non-empty: load the next head and pop on that same edge; stay in SEND with index 0.
  - Index 8 accepted, FIFO empty: go to IDLE.
  - Each accepted newline increments lines_out.
- FIFO: circular buffer with wrapping read/write pointers and an occupancy counter of log2(DEPTH)+1 bits.
  - A push and a pop on the same edge leave occupancy unchanged.
  - A push is never accepted while full, even if a pop occurs on that edge.

## Timing
- Reset values: state = IDLE, FIFO empty, ev_ready = 1, tx_valid = 0, tx_byte = 8'h00, tx_last = 0, busy = 0, err = 0, lines_out = 0.
- Reset asserted mid-line discards the partial line and all FIFO contents. There is no resumption after reset.
- Latency: an event accepted at edge k into an empty, idle block gives tx_valid = 1 with the type byte from edge k+1.
- Throughput with tx_ready held at 1: one byte per cycle, with no bubble between lines. Back-to-back events therefore produce 9 bytes every 9 cycles.
- Hold rule: while tx_valid && !tx_ready, tx_byte and tx_last are held stable.
- tx_valid never drops until its byte is accepted.
- ev_ready is a registered-state function (!full). It deasserts on the edge where the DEPTH-th entry is written.
- busy is combinational: busy = (state == SEND) || !fifo_empty.

## Test plan
- Single event: type 2, addr 16'o001000, tx_ready = 1. Expect bytes 32 20 30 30 31 30 30 30 0A on consecutive cycles, tx_last only on 0A, and lines_out = 1.
- Address extremes: type 1 with addr 16'hFFFF, then type 0 with addr 16'h0000. Expect "1 177777\n" then "0 000000\n", with no idle cycle between the two lines.
- Backpressure: tx_ready toggled 1,0,0,1,… during a line. Every byte must be emitted exactly once in order, and tx_byte must stay stable while stalled.
- FIFO full (DEPTH = 8): hold tx_ready = 0 and offer 10 events. Expect the first event loaded into SEND and 8 held in the FIFO, so ev_ready = 0 on the 10th. Then release tx_ready and check all 9 lines in order, with lines_out = 9.
- Illegal type: offer type 3, addr 16'o000100. Expect it accepted, err = 1, and no bytes emitted. A following valid event then emits normally while err stays 1.
- Reset mid-line: assert rst_n = 0 after 4 bytes of the line for 16'o000200, with 2 events queued. Expect every output at its reset value. After release, no bytes appear until a new event is offered.
